// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared mode codes, fixed code words and TERC4 lookup for the TMDS encoder
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL   = 3'd0,
      MODE_VIDEO  = 3'd1,
      MODE_TERC4  = 3'd2,
      MODE_VGUARD = 3'd3,
      MODE_DGUARD = 3'd4
   } mode_e;

   localparam int CNT_W = 5;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   // GUARD_A: video guard on lanes 0/2; GUARD_B: video guard lane 1 and data-island guard lanes 1/2
   localparam logic [9:0] GUARD_A = 10'b1011001100;
   localparam logic [9:0] GUARD_B = 10'b0100110011;

   function automatic logic [9:0] ctrl_word(input logic [1:0] c);
      logic [9:0] w;
      case (c)
         2'b00:   w = CTRL_00;
         2'b01:   w = CTRL_01;
         2'b10:   w = CTRL_10;
         default: w = CTRL_11;
      endcase
      return w;
   endfunction

   function automatic logic [9:0] terc4_word(input logic [3:0] nib);
      logic [9:0] w;
      case (nib)
         4'h0:    w = 10'b1010011100;
         4'h1:    w = 10'b1001100011;
         4'h2:    w = 10'b1011100100;
         4'h3:    w = 10'b1011100010;
         4'h4:    w = 10'b0101110001;
         4'h5:    w = 10'b0100011110;
         4'h6:    w = 10'b0110001110;
         4'h7:    w = 10'b0100111100;
         4'h8:    w = 10'b1011001100;
         4'h9:    w = 10'b0100111001;
         4'hA:    w = 10'b0110011100;
         4'hB:    w = 10'b1011000110;
         4'hC:    w = 10'b1010001110;
         4'hD:    w = 10'b1001110001;
         4'hE:    w = 10'b0101100011;
         default: w = 10'b1011000011;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/tmds_ch_enc.sv
// rtl/tmds_ch_enc.sv - one TMDS channel: three-stage symbol pipeline with running disparity
module tmds_ch_enc
   import tmds_pkg::*;
(
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       ce_i,
   input  logic [1:0] role_i,
   input  logic [2:0] mode_i,
   input  logic [7:0] data_i,
   input  logic [1:0] ctrl_i,
   input  logic [3:0] terc_i,
   output logic [9:0] data_o
);

   mode_e                    w_mode;
   logic [3:0]               w_n1d;
   logic                     w_use_xnor;
   logic [8:0]               w_qm;
   logic [3:0]               w_n1;
   logic [3:0]               w_n0;
   logic signed [CNT_W-1:0]  w_diff;
   logic [9:0]               w_sym;
   logic signed [CNT_W-1:0]  w_cnt_nxt;

   mode_e                    r1_mode;
   logic [7:0]               r1_data;
   logic [1:0]               r1_ctrl;
   logic [3:0]               r1_terc;
   logic [3:0]               r1_n1d;
   mode_e                    r2_mode;
   logic [8:0]               r2_qm;
   logic [3:0]               r2_n1;
   logic [3:0]               r2_n0;
   logic [1:0]               r2_ctrl;
   logic [3:0]               r2_terc;
   logic signed [CNT_W-1:0]  r_cnt;

   // fold the reserved mode codes onto CTRL before they enter the pipeline
   always_comb begin
      w_mode = MODE_CTRL;
      case (mode_i)
         3'd1:    w_mode = MODE_VIDEO;
         3'd2:    w_mode = MODE_TERC4;
         3'd3:    w_mode = MODE_VGUARD;
         3'd4:    w_mode = MODE_DGUARD;
         default: w_mode = MODE_CTRL;
      endcase
   end

   assign w_n1d      = 4'($countones(data_i));
   assign w_use_xnor = (r1_n1d > 4'd4) || ((r1_n1d == 4'd4) && !r1_data[0]);

   // transition-minimised word built as a serial XOR/XNOR chain over the byte
   always_comb begin
      logic [8:0] v_qm;
      v_qm    = '0;
      v_qm[0] = r1_data[0];
      for (int i = 1; i < 8; i++) begin
         v_qm[i] = w_use_xnor ? ~(v_qm[i-1] ^ r1_data[i]) : (v_qm[i-1] ^ r1_data[i]);
      end
      v_qm[8] = ~w_use_xnor;
      w_qm    = v_qm;
   end

   assign w_n1   = 4'($countones(w_qm[7:0]));
   assign w_n0   = 4'd8 - w_n1;
   assign w_diff = $signed({1'b0, r2_n1}) - $signed({1'b0, r2_n0});

   // output symbol select and disparity update; non-video symbols clear the disparity
   always_comb begin
      w_sym     = CTRL_00;
      w_cnt_nxt = '0;
      case (r2_mode)
         MODE_VIDEO: begin
            if ((r_cnt == '0) || (r2_n1 == r2_n0)) begin
               w_sym     = {~r2_qm[8], r2_qm[8], r2_qm[8] ? r2_qm[7:0] : ~r2_qm[7:0]};
               w_cnt_nxt = r2_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
            end else if ((!r_cnt[CNT_W-1] && (r2_n1 > r2_n0)) ||
                         ( r_cnt[CNT_W-1] && (r2_n0 > r2_n1))) begin
               w_sym     = {1'b1, r2_qm[8], ~r2_qm[7:0]};
               w_cnt_nxt = r_cnt + (r2_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
            end else begin
               w_sym     = {1'b0, r2_qm[8], r2_qm[7:0]};
               w_cnt_nxt = r_cnt + w_diff - (r2_qm[8] ? 5'sd0 : 5'sd2);
            end
         end
         MODE_TERC4:  w_sym = terc4_word(r2_terc);
         MODE_VGUARD: w_sym = (role_i == 2'd1) ? GUARD_B : GUARD_A;
         MODE_DGUARD: w_sym = (role_i == 2'd0) ? terc4_word(r2_terc) : GUARD_B;
         default:     w_sym = ctrl_word(r2_ctrl);
      endcase
   end

   // three pipeline stages plus disparity, all frozen while ce_i is low
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r1_mode <= MODE_CTRL;
         r1_data <= '0;
         r1_ctrl <= '0;
         r1_terc <= '0;
         r1_n1d  <= '0;
         r2_mode <= MODE_CTRL;
         r2_qm   <= '0;
         r2_n1   <= '0;
         r2_n0   <= '0;
         r2_ctrl <= '0;
         r2_terc <= '0;
         r_cnt   <= '0;
         data_o  <= '0;
      end else if (ce_i) begin
         r1_mode <= w_mode;
         r1_data <= data_i;
         r1_ctrl <= ctrl_i;
         r1_terc <= terc_i;
         r1_n1d  <= w_n1d;
         r2_mode <= r1_mode;
         r2_qm   <= w_qm;
         r2_n1   <= w_n1;
         r2_n0   <= w_n0;
         r2_ctrl <= r1_ctrl;
         r2_terc <= r1_terc;
         r_cnt   <= w_cnt_nxt;
         data_o  <= w_sym;
      end
   end

endmodule

// File: rtl/tmds_encoder_mc.sv
// rtl/tmds_encoder_mc.sv - multi-channel TMDS encoder sharing mode, enable and pipeline timing
module tmds_encoder_mc
   import tmds_pkg::*;
#(
   parameter int NUM_CH = 3
) (
   input  logic                   pclk,
   input  logic                   rst_n,
   input  logic                   ce_i,
   input  logic [2:0]             mode_i,
   input  logic [8*NUM_CH-1:0]    data_i,
   input  logic [2*NUM_CH-1:0]    ctrl_i,
   input  logic [4*NUM_CH-1:0]    terc_i,
   output logic [10*NUM_CH-1:0]   data_o
);

   // one encoder per lane; lane role repeats every three channels
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [1:0] ROLE = 2'(k % 3);
      tmds_ch_enc u_ch (
         .pclk   (pclk),
         .rst_n  (rst_n),
         .ce_i   (ce_i),
         .role_i (ROLE),
         .mode_i (mode_i),
         .data_i (data_i[8*k +: 8]),
         .ctrl_i (ctrl_i[2*k +: 2]),
         .terc_i (terc_i[4*k +: 4]),
         .data_o (data_o[10*k +: 10])
      );
   end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// tb/tb_tmds_encoder_mc.sv - directed vector bench for the three-lane TMDS encoder
module tb_tmds_encoder_mc;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic        ce_i;
   logic [2:0]  mode_i;
   logic [23:0] data_i;
   logic [5:0]  ctrl_i;
   logic [11:0] terc_i;
   logic [29:0] data_o;

   int n_vec = 0;
   int n_err = 0;

   tmds_encoder_mc #(.NUM_CH(3)) dut (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .ce_i   (ce_i),
      .mode_i (mode_i),
      .data_i (data_i),
      .ctrl_i (ctrl_i),
      .terc_i (terc_i),
      .data_o (data_o)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [2:0]  mode;
      logic [23:0] data;
      logic [5:0]  ctrl;
      logic [11:0] terc;
      logic [29:0] exp;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   localparam logic [9:0] W_C00 = 10'b1101010100;
   localparam logic [9:0] W_GA  = 10'b1011001100;
   localparam logic [9:0] W_GB  = 10'b0100110011;

   task automatic check(input string nm, input logic [29:0] act, input logic [29:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: data_o=%b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                        input logic [11:0] t, input logic ce);
      mode_i = m;
      data_i = d;
      ctrl_i = c;
      terc_i = t;
      ce_i   = ce;
   endtask

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   // behavioural video reference, counted with plain integers
   function automatic logic [9:0] ref_video(input logic [7:0] d, input int cin, output int cout);
      logic [8:0] qm;
      int n1d, n1, n0;
      bit use_xnor;
      logic [9:0] o;
      n1d = 0;
      for (int i = 0; i < 8; i++) n1d += int'(d[i]);
      use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (cin == 0 || n1 == n0) begin
         o    = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cout = qm[8] ? cin + n1 - n0 : cin + n0 - n1;
      end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
         o    = {1'b1, qm[8], ~qm[7:0]};
         cout = cin + 2 * int'(qm[8]) + n0 - n1;
      end else begin
         o    = {1'b0, qm[8], qm[7:0]};
         cout = cin + n1 - n0 - 2 * int'(!qm[8]);
      end
      return o;
   endfunction

   logic [23:0] items  [22];
   logic [29:0] expout [22];

   initial begin
      int mcnt [3];
      int nc;
      int e_last;
      int idx;
      int cyc;

      vecs[0]  = '{3'd0, 24'h0, {2'b10, 2'b01, 2'b00}, 12'h0,
                   {10'b0101010100, 10'b0010101011, W_C00}};
      vecs[1]  = '{3'd0, 24'h0, 6'b111111, 12'h0, {3{10'b1010101011}}};
      vecs[2]  = '{3'd7, 24'h0, 6'b000000, 12'h0, {3{W_C00}}};
      vecs[3]  = '{3'd2, 24'h0, 6'b0, {4'hF, 4'h0, 4'hA},
                   {10'b1011000011, 10'b1010011100, 10'b0110011100}};
      vecs[4]  = '{3'd3, 24'h0, 6'b0, 12'h0, {W_GA, W_GB, W_GA}};
      vecs[5]  = '{3'd4, 24'h0, 6'b0, {4'h5, 4'h5, 4'hC}, {W_GB, W_GB, 10'b1010001110}};
      vecs[6]  = '{3'd1, 24'h000000, 6'b0, 12'h0, {3{10'b0100000000}}};
      vecs[7]  = '{3'd1, 24'h000000, 6'b0, 12'h0, {3{10'b1111111111}}};
      vecs[8]  = '{3'd0, 24'h0, 6'b0, 12'h0, {3{W_C00}}};
      vecs[9]  = '{3'd1, 24'h000000, 6'b0, 12'h0, {3{10'b0100000000}}};
      vecs[10] = '{3'd1, 24'hFFFFFF, 6'b0, 12'h0, {3{10'b0011111111}}};
      vecs[11] = '{3'd1, 24'h555555, 6'b0, 12'h0, {3{10'b0100110011}}};
      vecs[12] = '{3'd1, 24'h55FF00, 6'b0, 12'h0,
                   {10'b0100110011, 10'b0011111111, 10'b1111111111}};

      // reset held low: outputs stay zero across edges
      rst_n = 1'b0;
      drive(3'd0, 24'h0, 6'b0, 12'h0, 1'b1);
      tick; tick; tick;
      check("reset_hold", data_o, 30'h0);
      rst_n = 1'b1;

      // table: vector i enters at edge i and is visible after edge i+2
      for (int i = 0; i < NV + 2; i++) begin
         if (i < NV) drive(vecs[i].mode, vecs[i].data, vecs[i].ctrl, vecs[i].terc, 1'b1);
         else        drive(3'd0, 24'h0, 6'b0, 12'h0, 1'b1);
         tick;
         if (i >= 2) check($sformatf("table[%0d]", i - 2), data_o, vecs[i-2].exp);
      end

      // clock-enable gap inside a random video stream
      for (int c = 0; c < 3; c++) mcnt[c] = 0;
      for (int j = 0; j < 22; j++) begin
         items[j] = 24'($urandom);
         for (int c = 0; c < 3; c++) begin
            expout[j][10*c +: 10] = ref_video(items[j][8*c +: 8], mcnt[c], nc);
            mcnt[c] = nc;
         end
      end
      e_last = -1;
      idx    = 0;
      cyc    = 0;
      while (idx < 22 && cyc < 200) begin
         if (cyc >= 8 && cyc < 13) drive(3'd1, 24'($urandom), 6'b0, 12'h0, 1'b0);
         else                      drive(3'd1, items[idx], 6'b0, 12'h0, 1'b1);
         tick;
         if (ce_i) begin
            e_last = idx;
            idx++;
         end
         if (e_last >= 2) check($sformatf("ce_stream[%0d]", cyc), data_o, expout[e_last-2]);
         cyc++;
      end
      if (idx < 22) check("ce_stream_budget", 30'h1, 30'h0);

      // mid-frame asynchronous reset
      drive(3'd1, 24'h123456, 6'b0, 12'h0, 1'b1);
      tick; tick;
      #2 rst_n = 1'b0;
      #1 check("async_reset", data_o, 30'h0);
      tick;
      check("reset_hold_edge", data_o, 30'h0);
      drive(3'd0, 24'h0, 6'b0, 12'h0, 1'b1);
      rst_n = 1'b1;
      tick; tick;
      drive(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1);
      tick;
      check("post_reset_ctrl", data_o, {3{W_C00}});
      drive(3'd0, 24'h0, 6'b0, 12'h0, 1'b1);
      tick; tick;
      check("post_reset_video", data_o, {3{10'b0100000000}});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tmds_encoder_mc.md
# tmds_encoder_mc

Multi-channel, multi-mode TMDS encoder for the HDMI transmit path. It sits between the video/data-island packetiser and the 10:1 serialisers. Per channel and per pixel clock it produces one 10-bit symbol, chosen per cycle from five modes: DC-balanced 8b/10b video, 2-bit control, TERC4 data island, video guard band, or data-island guard band. All channels share one mode, one clock enable and one fixed pipeline, so their outputs stay symbol-aligned.

## Interface
Parameters:
- NUM_CH, default 3: number of TMDS channels; must be 1 or more. Channel k plays HDMI lane role k mod 3.

Ports (clock and reset first):
- pclk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ce_i  in  1  clock enable. When 0, the whole pipeline and all disparity counters hold.
- mode_i  in  3  0=CTRL, 1=VIDEO, 2=TERC4, 3=VGUARD, 4=DGUARD. Codes 5–7 are treated as CTRL.
- data_i  in  8*NUM_CH  video byte. Channel k uses bits [8k+7:8k].
- ctrl_i  in  2*NUM_CH  control pair {C1,C0}. Channel k uses bits [2k+1:2k].
- terc_i  in  4*NUM_CH  TERC4 nibble. Channel k uses bits [4k+3:4k].
- data_o  out  10*NUM_CH  encoded symbol, registered. Channel k drives bits [10k+9:10k]. Reset value is all zeros.

## Operation
All code words below are written as bit 9 first, down to bit 0.

- **CTRL mode.** {C1,C0} maps as: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- **TERC4 mode.** Nibble 0..15 maps to: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- **VGUARD mode.** Lane role 1 outputs 0100110011. Roles 0 and 2 output 1011001100.
- **DGUARD mode.** Role 0 outputs TERC4(terc_i); the packetiser supplies {1,1,VS,HS}. Roles 1 and 2 output 0100110011.
- **VIDEO mode, transition minimisation:**
  - n1d = number of ones in the data byte.
  - Use XNOR when n1d>4, or when n1d==4 and d[0]==0; otherwise use XOR.
  - q_m[0]=d[0]; q_m[i]=q_m[i-1] XOR/XNOR d[i].
  - q_m[8]=1 for XOR, 0 for XNOR.
- **VIDEO mode, DC balance.** n1 and n0 are the ones and zeros counts of q_m[7:0]. cnt is a signed 5-bit running disparity per channel.
  - If cnt==0 or n1==n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? n1−n0 : n0−n1.
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2·q_m[8] + n0 − n1.
  - Else: out = {0, q_m[8], q_m[7:0]}. cnt += n1 − n0 − 2·(~q_m[8]).
  - |cnt| never exceeds 10. The 5-bit signed width is sufficient; wrap is never legal.
- **Disparity reset.** cnt is forced to 0 on every enabled cycle whose output-stage mode is not VIDEO.
- **Mode alignment.** Mode is pipelined alongside the data, so mode changes take effect symbol-exactly, with no mixing between modes.

## Timing
- **Pipeline stages:**
  - S1 registers the inputs, mode and n1d.
  - S2 registers q_m, n1 and n0.
  - S3 registers data_o and cnt.
- **Latency.** Inputs sampled at enabled edge t appear on data_o after enabled edge t+2 (3 register stages). Latency is identical for every mode.
- **ce_i=0.** All stages, data_o and cnt hold their values. The output sequence is the ungated sequence with repeats inserted.
- **Reset.** rst_n low clears all stages asynchronously, at any time, including mid-stream: data_o=0, cnt=0, stage modes=CTRL. After release, the first meaningful symbol appears 3 enabled edges later.
- **Channel independence.** Channels never interact except through shared mode and ce_i.

## Structure
- Package tmds_pkg holds:
  - mode encodings (MODE_CTRL … MODE_DGUARD);
  - the four control words and two guard words;
  - the TERC4 lookup function;
  - the disparity width constant (5).
- Sub-module tmds_ch_enc is one channel (S1–S3 datapath plus cnt), with a lane-role input. The top level generates NUM_CH instances and owns nothing else.

## Test plan
- **Reset.** Hold rst_n low → data_o=0. Release with mode=CTRL and ctrl=00 on all 3 channels → every channel shows 1101010100 after the 3rd edge.
- **Video disparity.** mode=VIDEO, data=8'h00 twice from cnt=0 → 0100000000 (cnt=−8), then 1111111111 (cnt=+2).
- **TERC4.** terc=4'hA → 0110011100. terc=4'h0 → 1010011100. In both cases cnt reads 0 afterwards.
- **Guard bands.** VGUARD on 3 channels → 1011001100 / 0100110011 / 1011001100. DGUARD with terc0=4'hC → 1010001110 / 0100110011 / 0100110011.
- **Clock enable.** Random video with ce_i low for 5 cycles mid-stream → output equals the ungated reference with held symbols; cnt is unchanged across the gap.
- **Mode switch.** VIDEO→CTRL (1 cycle)→VIDEO with 8'h00 → the first new video symbol is 0100000000 (cnt restarted at 0). Asserting reset mid-frame → immediate zeros.
